// File: rtl/bcd_cascade_timer.sv
// rtl/bcd_cascade_timer.sv - cascaded per-digit-modulus up/down timer with IDLE/RUN/DONE control
module bcd_cascade_timer #(
   parameter int                      DIGITS   = 4,
   parameter int                      WIDTH    = 4,
   parameter logic [DIGITS*WIDTH-1:0] MAX_VEC  = 16'h9959,
   parameter bit                      ROLLOVER = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      load,
   input  logic [DIGITS*WIDTH-1:0]   start_count,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      tick,
   input  logic                      direction,
   output logic [DIGITS*WIDTH-1:0]   count,
   output logic                      zero_count,
   output logic                      full_count,
   output logic                      running,
   output logic                      terminal
);

   localparam int N = DIGITS * WIDTH;

   for (genvar g = 0; g < DIGITS; g++) begin : g_max_check
      if (MAX_VEC[g*WIDTH +: WIDTH] == '0) begin : g_bad_max
         $error("bcd_cascade_timer: every digit maximum must be at least 1");
      end
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   stepped;
   logic [N-1:0]   clamped;
   logic [N-1:0]   count_nxt;
   logic           at_limit;
   logic           step_en;
   logic           step_hits_limit;
   logic           term_nxt;

   assign zero_count      = (count == '0);
   assign full_count      = (count == MAX_VEC);
   assign at_limit        = direction ? full_count : zero_count;
   assign step_en         = (state == ST_RUN) && tick && !load && !stop;
   assign step_hits_limit = direction ? (stepped == MAX_VEC) : (stepped == '0);
   // Saturating mode flags landing on the limit; wrap mode flags leaving it.
   assign term_nxt        = step_en && (ROLLOVER ? at_limit : step_hits_limit);

   // Ripple the borrow/carry: a digit moves only when all lower digits sit on their boundary.
   always_comb begin
      logic             carry;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] m;
      stepped = count;
      carry   = 1'b1;
      d       = '0;
      m       = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = count[i*WIDTH +: WIDTH];
         m = MAX_VEC[i*WIDTH +: WIDTH];
         if (carry) begin
            if (direction)
               stepped[i*WIDTH +: WIDTH] = (d == m) ? '0 : d + WIDTH'(1);
            else
               stepped[i*WIDTH +: WIDTH] = (d == '0) ? m : d - WIDTH'(1);
         end
         carry = carry && (direction ? (d == m) : (d == '0));
      end
   end

   always_comb begin
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] m;
      clamped = '0;
      d       = '0;
      m       = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = start_count[i*WIDTH +: WIDTH];
         m = MAX_VEC[i*WIDTH +: WIDTH];
         clamped[i*WIDTH +: WIDTH] = (d > m) ? m : d;
      end
   end

   always_comb begin
      count_nxt = count;
      if (load)
         count_nxt = clamped;
      else if (step_en)
         count_nxt = stepped;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load) begin
         state_nxt = ST_IDLE;
      end else if (stop) begin
         if (state == ST_RUN)
            state_nxt = ST_IDLE;
      end else if (start && (state != ST_RUN)) begin
         state_nxt = (ROLLOVER || !at_limit) ? ST_RUN : ST_DONE;
      end else if (step_en && !ROLLOVER && step_hits_limit) begin
         state_nxt = ST_DONE;
      end
   end

   always_comb begin
      running = (state == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         terminal <= 1'b0;
      end else begin
         count    <= count_nxt;
         terminal <= term_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_cascade_timer.sv
// tb/tb_bcd_cascade_timer.sv - table, directed and random checks of saturating and wrapping timers
`timescale 1ns/1ps
module tb_bcd_cascade_timer;

   localparam logic [15:0] MAXV = 16'h9959;

   logic        clk;
   logic        reset_n;
   logic        load;
   logic [15:0] start_count;
   logic        start;
   logic        stop;
   logic        tick;
   logic        direction;

   logic [15:0] count0, count1;
   logic        zero0, zero1, full0, full1, run0, run1, term0, term1;

   bcd_cascade_timer #(.DIGITS(4), .WIDTH(4), .MAX_VEC(MAXV), .ROLLOVER(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .start_count(start_count),
      .start(start), .stop(stop), .tick(tick), .direction(direction),
      .count(count0), .zero_count(zero0), .full_count(full0),
      .running(run0), .terminal(term0)
   );

   bcd_cascade_timer #(.DIGITS(4), .WIDTH(4), .MAX_VEC(MAXV), .ROLLOVER(1'b1)) dut_r (
      .clk(clk), .reset_n(reset_n), .load(load), .start_count(start_count),
      .start(start), .stop(stop), .tick(tick), .direction(direction),
      .count(count1), .zero_count(zero1), .full_count(full1),
      .running(run1), .terminal(term1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   // Reference: the count is a single integer in a mixed-radix system (radix = digit max + 1).
   int total;
   int m_val  [2];
   int m_st   [2];
   bit m_term [2];

   function automatic int rad(int i);
      logic [15:0] mv;
      mv = MAXV;
      return int'(mv[i*4 +: 4]) + 1;
   endfunction

   function automatic int enc(logic [15:0] v);
      int acc, mult, d;
      acc  = 0;
      mult = 1;
      for (int i = 0; i < 4; i++) begin
         d = int'(v[i*4 +: 4]);
         if (d > rad(i) - 1) d = rad(i) - 1;
         acc  += d * mult;
         mult *= rad(i);
      end
      return acc;
   endfunction

   function automatic logic [15:0] dec(int v);
      logic [15:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(x % rad(i));
         x = x / rad(i);
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 2; r++) begin
         m_val[r]  = 0;
         m_st[r]   = 0;
         m_term[r] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int r = 0; r < 2; r++) begin
         int old;
         bit lim;
         m_term[r] = 1'b0;
         lim = direction ? (m_val[r] == total - 1) : (m_val[r] == 0);
         if (load) begin
            m_val[r] = enc(start_count);
            m_st[r]  = 0;
         end else if (stop) begin
            if (m_st[r] == 1) m_st[r] = 0;
         end else if (start && m_st[r] != 1) begin
            m_st[r] = (r == 1 || !lim) ? 1 : 2;
         end else if (m_st[r] == 1 && tick) begin
            old      = m_val[r];
            m_val[r] = (old + (direction ? 1 : total - 1)) % total;
            if (r == 1) begin
               m_term[r] = lim;
            end else begin
               m_term[r] = direction ? (m_val[r] == total - 1) : (m_val[r] == 0);
               if (m_term[r]) m_st[r] = 2;
            end
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_in(logic ld, logic [15:0] sc, logic st, logic sp, logic tk, logic dir);
      load = ld; start_count = sc; start = st; stop = sp; tick = tk; direction = dir;
   endtask

   task automatic cmp_model(int r, logic [15:0] c, logic rn, logic tm, logic z, logic f);
      chk($sformatf("rnd%0d_count", r),    c,  dec(m_val[r]));
      chk($sformatf("rnd%0d_running", r),  rn, (m_st[r] == 1));
      chk($sformatf("rnd%0d_terminal", r), tm, m_term[r]);
      chk($sformatf("rnd%0d_zero", r),     z,  (m_val[r] == 0));
      chk($sformatf("rnd%0d_full", r),     f,  (m_val[r] == total - 1));
   endtask

   typedef struct {
      logic        ld;
      logic [15:0] sc;
      logic        st;
      logic        sp;
      logic        tk;
      logic        dir;
      logic [15:0] ec;
      logic        er;
      logic        et;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int pulses;
      logic [15:0] pick [5];
      vectors     = 0;
      miscompares = 0;
      total = 1;
      for (int i = 0; i < 4; i++) total *= rad(i);

      tbl[0]  = '{1'b1, 16'h0A7F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0959, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0959, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 16'h9959, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9959, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h9959, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9959, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0059, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0059, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0059, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

      reset_n = 1'b0;
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #12;
      chk("reset_count", count0, 16'h0000);
      chk("reset_running", run0, 1'b0);
      chk("reset_terminal", term0, 1'b0);
      chk("reset_zero", zero0, 1'b1);
      chk("reset_full", full0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         set_in(tbl[i].ld, tbl[i].sc, tbl[i].st, tbl[i].sp, tbl[i].tk, tbl[i].dir);
         cyc();
         chk($sformatf("tbl%0d_count", i),    count0, tbl[i].ec);
         chk($sformatf("tbl%0d_running", i),  run0,   tbl[i].er);
         chk($sformatf("tbl%0d_terminal", i), term0,  tbl[i].et);
         chk($sformatf("tbl%0d_zero", i),     zero0,  (tbl[i].ec == 16'h0000));
         chk($sformatf("tbl%0d_full", i),     full0,  (tbl[i].ec == 16'h9959));
      end

      // Countdown 01:00 to 00:00 with a single terminal pulse, then saturation.
      set_in(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
      chk("cd_first", count0, 16'h0059);
      pulses = 0;
      for (int i = 0; i < 59; i++) begin
         cyc();
         if (term0) pulses++;
      end
      chk("cd_end_count", count0, 16'h0000);
      chk("cd_end_terminal", term0, 1'b1);
      chk("cd_end_running", run0, 1'b0);
      chk("cd_pulses", pulses, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("cd_hold_count", count0, 16'h0000);
         chk("cd_hold_terminal", term0, 1'b0);
      end

      // Wrap-around instance: down from zero, then up from max, pulse on each wrap.
      set_in(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
      chk("ro_start_running", run1, 1'b1);
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
      chk("ro_down_count", count1, 16'h9959);
      chk("ro_down_terminal", term1, 1'b1);
      chk("ro_down_running", run1, 1'b1);
      direction = 1'b1; cyc();
      chk("ro_up_count", count1, 16'h0000);
      chk("ro_up_terminal", term1, 1'b1);
      cyc();
      chk("ro_next_count", count1, 16'h0001);
      chk("ro_next_terminal", term1, 1'b0);

      // Asynchronous reset between edges while running.
      set_in(1'b1, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
      chk("rst_pre_count", count0, 16'h0459);
      tick = 1'b0;
      cyc();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_count", count0, 16'h0000);
      chk("rst_running", run0, 1'b0);
      chk("rst_terminal", term0, 1'b0);
      chk("rst_zero", zero0, 1'b1);
      chk("rst_r_count", count1, 16'h0000);
      chk("rst_r_running", run1, 1'b0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      pick[0] = 16'h0000; pick[1] = 16'h9959; pick[2] = 16'h0001; pick[3] = 16'h9958;
      for (int n = 0; n < 3000; n++) begin
         pick[4]   = 16'($urandom);
         load      = ($urandom_range(0, 31) == 0);
         start_count = pick[$urandom_range(0, 4)];
         start     = ($urandom_range(0, 7) == 0);
         stop      = ($urandom_range(0, 15) == 0);
         tick      = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) direction = ~direction;
         cyc();
         cmp_model(0, count0, run0, term0, zero0, full0);
         cmp_model(1, count1, run1, term1, zero1, full1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
